// File: rtl/lsu_pkg.sv
// lsu_pkg: types and constants shared by the load/store controller and the
// data memory.
//   - lsu_state_e       : controller state encoding
//   - DATA_W / ADDR_W   : data and word-address widths
//   - MEM_WORDS_DEFAULT : data memory depth in 32-bit words
//   - CNT_W             : width of the read-latency wait counter (READ_LAT <= 4)
//   - addr_in_range()   : unsigned full-width legality check for a word address
package lsu_pkg;

    localparam int DATA_W            = 32;
    localparam int ADDR_W            = 32;
    localparam int MEM_WORDS_DEFAULT = 6536;
    localparam int CNT_W             = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACCESS   = 3'd1,
        WAIT     = 3'd2,
        CAPTURE  = 3'd3,
        RESP     = 3'd4,
        ERR_RESP = 3'd5
    } lsu_state_e;

    // An address equal to the depth is already outside the memory.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input logic [ADDR_W-1:0] words);
        return (addr < words);
    endfunction

endpackage

// File: rtl/lsu_wait_counter.sv
// lsu_wait_counter: down-counter that times the memory read latency.
//   clock    in  rising-edge clock
//   reset    in  synchronous active-high reset, clears the count
//   load     in  load load_val on the next edge
//   load_val in  value to load (READ_LAT-1)
//   done     out count is zero
module lsu_wait_counter
    import lsu_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_r;

    // Load on request, otherwise count down and park at zero
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= W'(0);
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != W'(0)) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == W'(0));

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator for the single-port word-addressed data memory.
//   Parameters: MEM_WORDS (memory depth in words), READ_LAT (1..4 edges from a
//   sampled read strobe to valid read data).
//   clock, reset                         rising-edge clock, sync active-high reset
//   req_valid/req_ready/req_write/
//   req_addr/req_wdata                   request channel (valid/ready)
//   resp_valid/resp_ready/resp_rdata/
//   resp_err                             response channel (valid/ready)
//   stall                                busy, state != IDLE
//   mem_read/mem_write/mem_address/
//   mem_datain/mem_dataout               memory port (read data registered in memory)
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int READ_LAT  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    localparam logic [ADDR_W-1:0] MEM_WORDS_C = ADDR_W'(MEM_WORDS);
    localparam logic [CNT_W-1:0]  WAIT_LOAD_C = CNT_W'(READ_LAT - 1);

    lsu_state_e        state_r;
    lsu_state_e        next_state_s;
    logic              wr_r;
    logic              req_ready_s;
    logic              accept_s;
    logic              enter_access_s;
    logic              wait_done_s;

    logic              resp_valid_r;
    logic              resp_err_r;
    logic [DATA_W-1:0] resp_rdata_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic [ADDR_W-1:0] mem_address_r;
    logic [DATA_W-1:0] mem_datain_r;

    logic              resp_valid_next_s;
    logic              resp_err_next_s;
    logic [DATA_W-1:0] resp_rdata_next_s;
    logic              mem_read_next_s;
    logic              mem_write_next_s;
    logic [ADDR_W-1:0] mem_address_next_s;
    logic [DATA_W-1:0] mem_datain_next_s;

    assign req_ready_s    = (state_r == IDLE) && !reset;
    assign accept_s       = req_valid && req_ready_s;
    // ACCESS is only reachable from IDLE through an in-range accept.
    assign enter_access_s = (next_state_s == ACCESS);

    // Counter is loaded as ACCESS starts, so it has already stepped once by
    // the first WAIT cycle and WAIT lasts exactly READ_LAT-1 cycles.
    lsu_wait_counter #(
        .W (CNT_W)
    ) u_wait_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (enter_access_s),
        .load_val (WAIT_LOAD_C),
        .done     (wait_done_s)
    );

    // State register plus the captured request direction
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            wr_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            wr_r    <= accept_s ? req_write : wr_r;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (addr_in_range(req_addr, MEM_WORDS_C)) begin
                        next_state_s = ACCESS;
                    end else begin
                        next_state_s = ERR_RESP;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS: begin
                if (wr_r) begin
                    next_state_s = RESP;
                end else if (READ_LAT > 1) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = CAPTURE;
                end
            end
            WAIT: begin
                if (wait_done_s) begin
                    next_state_s = CAPTURE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            CAPTURE: begin
                next_state_s = RESP;
            end
            RESP, ERR_RESP: begin
                if (resp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output decode: next values of the registered outputs, looked ahead from
    // the next state so strobes and responses line up with their states
    always_comb begin
        mem_read_next_s    = enter_access_s && !req_write;
        mem_write_next_s   = enter_access_s && req_write;
        mem_address_next_s = mem_address_r;
        mem_datain_next_s  = mem_datain_r;
        resp_valid_next_s  = (next_state_s == RESP) || (next_state_s == ERR_RESP);
        resp_err_next_s    = (next_state_s == ERR_RESP);
        resp_rdata_next_s  = resp_rdata_r;

        if (enter_access_s) begin
            mem_address_next_s = req_addr;
            mem_datain_next_s  = req_wdata;
        end else begin
            mem_address_next_s = mem_address_r;
            mem_datain_next_s  = mem_datain_r;
        end

        if (state_r == CAPTURE) begin
            resp_rdata_next_s = mem_dataout;
        end else if ((next_state_s == ERR_RESP) ||
                     ((state_r == ACCESS) && (next_state_s == RESP))) begin
            resp_rdata_next_s = {DATA_W{1'b0}};
        end else begin
            resp_rdata_next_s = resp_rdata_r;
        end
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_r  <= 1'b0;
            resp_err_r    <= 1'b0;
            resp_rdata_r  <= {DATA_W{1'b0}};
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_address_r <= {ADDR_W{1'b0}};
            mem_datain_r  <= {DATA_W{1'b0}};
        end else begin
            resp_valid_r  <= resp_valid_next_s;
            resp_err_r    <= resp_err_next_s;
            resp_rdata_r  <= resp_rdata_next_s;
            mem_read_r    <= mem_read_next_s;
            mem_write_r   <= mem_write_next_s;
            mem_address_r <= mem_address_next_s;
            mem_datain_r  <= mem_datain_next_s;
        end
    end

    assign req_ready   = req_ready_s;
    assign stall       = (state_r != IDLE);
    assign resp_valid  = resp_valid_r;
    assign resp_err    = resp_err_r;
    assign resp_rdata  = resp_rdata_r;
    assign mem_read    = mem_read_r;
    assign mem_write   = mem_write_r;
    assign mem_address = mem_address_r;
    assign mem_datain  = mem_datain_r;

endmodule
